// File: rtl/controlador_bebidas_fsm.sv
// rtl/controlador_bebidas_fsm.sv - beverage dispense controller: credit, selection, timed prep stages, change return
module controlador_bebidas_fsm #(
    parameter int CREDIT_W    = 12,
    parameter int MAX_CREDIT  = 3000,
    parameter int PREP_CYCLES = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin100,
    input  logic                coin500,
    input  logic [2:0]          sel,
    input  logic                cancel,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy,
    output logic                prep_water,
    output logic                prep_mix,
    output logic                change100,
    output logic                coin_reject,
    output logic                insufficient,
    output logic                done
);

    localparam int CNT_W = (PREP_CYCLES > 1) ? $clog2(PREP_CYCLES) : 1;
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(PREP_CYCLES - 1);
    localparam logic [CREDIT_W:0]   MAX_SUM  = (CREDIT_W+1)'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0] UNIT     = CREDIT_W'(100);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHECK  = 3'd1,
        WATER  = 3'd2,
        MIX    = 3'd3,
        CHANGE = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    stage_cnt;
    logic [2:0]          sel_q;
    logic                served;

    logic                coin_any;
    logic [CREDIT_W:0]   coin_amt;
    logic [CREDIT_W:0]   coin_sum;
    logic                coin_fits;
    logic [CREDIT_W-1:0] credit_new;
    logic                sel_valid;
    logic [CREDIT_W-1:0] price;

    always_comb begin
        coin_any = coin100 | coin500;
        coin_amt = '0;
        if (coin100) coin_amt = coin_amt + (CREDIT_W+1)'(100);
        if (coin500) coin_amt = coin_amt + (CREDIT_W+1)'(500);
        coin_sum  = {1'b0, credit} + coin_amt;
        coin_fits = (coin_sum <= MAX_SUM);
        // Credit as seen by cancel this cycle, including a coin accepted alongside it
        credit_new = (coin_any && coin_fits) ? coin_sum[CREDIT_W-1:0] : credit;
        sel_valid  = (sel >= 3'd1) && (sel <= 3'd5);
    end

    always_comb begin
        price = '0;
        case (sel_q)
            3'd1:    price = CREDIT_W'(300);
            3'd2:    price = CREDIT_W'(500);
            3'd3:    price = CREDIT_W'(600);
            3'd4:    price = CREDIT_W'(800);
            3'd5:    price = CREDIT_W'(1000);
            default: price = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            credit       <= '0;
            stage_cnt    <= '0;
            sel_q        <= '0;
            served       <= 1'b0;
            busy         <= 1'b0;
            prep_water   <= 1'b0;
            prep_mix     <= 1'b0;
            change100    <= 1'b0;
            coin_reject  <= 1'b0;
            insufficient <= 1'b0;
            done         <= 1'b0;
        end else begin
            change100    <= 1'b0;
            coin_reject  <= 1'b0;
            insufficient <= 1'b0;
            done         <= 1'b0;

            if (state != IDLE && coin_any) begin
                coin_reject <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (coin_any) begin
                        if (coin_fits) credit <= coin_sum[CREDIT_W-1:0];
                        else           coin_reject <= 1'b1;
                    end
                    if (cancel && credit_new != '0) begin
                        served <= 1'b0;
                        busy   <= 1'b1;
                        state  <= CHANGE;
                    end else if (sel_valid) begin
                        sel_q <= sel;
                        busy  <= 1'b1;
                        state <= CHECK;
                    end
                end

                CHECK: begin
                    if (credit >= price) begin
                        credit     <= credit - price;
                        stage_cnt  <= '0;
                        prep_water <= 1'b1;
                        state      <= WATER;
                    end else begin
                        insufficient <= 1'b1;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end
                end

                WATER: begin
                    if (stage_cnt == CNT_LAST) begin
                        stage_cnt  <= '0;
                        prep_water <= 1'b0;
                        prep_mix   <= 1'b1;
                        state      <= MIX;
                    end else begin
                        stage_cnt <= stage_cnt + CNT_W'(1);
                    end
                end

                MIX: begin
                    if (stage_cnt == CNT_LAST) begin
                        stage_cnt <= '0;
                        prep_mix  <= 1'b0;
                        served    <= 1'b1;
                        state     <= CHANGE;
                    end else begin
                        stage_cnt <= stage_cnt + CNT_W'(1);
                    end
                end

                CHANGE: begin
                    // The last unit of change and the exit happen on the same edge
                    if (credit >= UNIT) begin
                        change100 <= 1'b1;
                        credit    <= credit - UNIT;
                    end
                    if (credit <= UNIT) begin
                        if (served) begin
                            state <= DONE;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end

                DONE: begin
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    served <= 1'b0;
                    state  <= IDLE;
                end

                default: begin
                    busy       <= 1'b0;
                    prep_water <= 1'b0;
                    prep_mix   <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule
